// File: rtl/nfp_merge_avlstrm.sv
// Two-input packet-granular merge onto one Avalon-ST stream.
// Round-robin on sop, lock until eop, single output register stage.
module nfp_merge_avlstrm #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_valid,
  input  logic               in0_sop,
  input  logic               in0_eop,
  input  logic [EMPTY_W-1:0] in0_empty,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_valid,
  input  logic               in1_sop,
  input  logic               in1_eop,
  input  logic [EMPTY_W-1:0] in1_empty,
  output logic               in1_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   stats_in0_pkt,
  output logic [CNT_W-1:0]   stats_in1_pkt,
  output logic [CNT_W-1:0]   stats_out_pkt,
  output logic [CNT_W-1:0]   stats_drop_beat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   rr_last, rr_nx;
  logic   can_load;
  logic   sop0, sop1;
  logic   grant0, grant1;
  logic   acc0, acc1;
  logic   drop0, drop1;
  logic   fwd0, fwd1;
  logic   idle;

  assign idle     = (state == IDLE);
  assign can_load = ~out_valid | out_ready;
  assign sop0     = in0_valid & in0_sop;
  assign sop1     = in1_valid & in1_sop;

  // rr_last names the input served last; the other one wins a tie
  assign grant0 = sop0 & (~sop1 | rr_last);
  assign grant1 = sop1 & (~sop0 | ~rr_last);

  assign acc0  = in0_valid & in0_ready;
  assign acc1  = in1_valid & in1_ready;
  assign drop0 = acc0 & idle & ~in0_sop;
  assign drop1 = acc1 & idle & ~in1_sop;
  assign fwd0  = acc0 & ~drop0;
  assign fwd1  = acc1 & ~drop1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nx;
      rr_last <= rr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr_last;
    unique case (state)
      IDLE: begin
        if (fwd0) begin
          if (in0_eop) rr_nx = 1'b0;
          else         state_nx = LOCK0;
        end else if (fwd1) begin
          if (in1_eop) rr_nx = 1'b1;
          else         state_nx = LOCK1;
        end
      end
      LOCK0: begin
        if (fwd0 & in0_eop) begin
          state_nx = IDLE;
          rr_nx    = 1'b0;
        end
      end
      LOCK1: begin
        if (fwd1 & in1_eop) begin
          state_nx = IDLE;
          rr_nx    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // orphan beats in IDLE are swallowed regardless of out_ready
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (!Rst) begin
      unique case (state)
        IDLE: begin
          in0_ready = (grant0 & can_load) | (in0_valid & ~in0_sop);
          in1_ready = (grant1 & can_load) | (in1_valid & ~in1_sop);
        end
        LOCK0:   in0_ready = can_load;
        LOCK1:   in1_ready = can_load;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (fwd0 | fwd1) begin
      out_valid <= 1'b1;
      out_sop   <= fwd1 ? in1_sop : in0_sop;
      out_eop   <= fwd1 ? in1_eop : in0_eop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (fwd0 | fwd1) begin
      out_data  <= fwd1 ? in1_data : in0_data;
      out_empty <= fwd1 ? in1_empty : in0_empty;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stats_in0_pkt   <= '0;
      stats_in1_pkt   <= '0;
      stats_out_pkt   <= '0;
      stats_drop_beat <= '0;
    end else begin
      stats_in0_pkt   <= stats_in0_pkt + CNT_W'(fwd0 & in0_eop);
      stats_in1_pkt   <= stats_in1_pkt + CNT_W'(fwd1 & in1_eop);
      stats_out_pkt   <= stats_out_pkt
                       + CNT_W'(out_valid & out_ready & out_eop);
      stats_drop_beat <= stats_drop_beat
                       + CNT_W'(drop0) + CNT_W'(drop1);
    end
  end

endmodule

// File: tb/tb_nfp_merge_avlstrm.sv
// Directed bench for nfp_merge_avlstrm with queue scoreboard.
// Narrow widths (CNT_W=4) make counter wrap reachable by traffic.
module tb_nfp_merge_avlstrm;

  localparam int DW = 32;
  localparam int EW = 2;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] e;
  } beat_t;

  logic          Clk, Rst;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          in0_valid, in0_sop, in0_eop, in0_ready;
  logic          in1_valid, in1_sop, in1_eop, in1_ready;
  logic [EW-1:0] in0_empty, in1_empty, out_empty;
  logic          out_valid, out_sop, out_eop, out_ready;
  logic [CW-1:0] stats_in0_pkt, stats_in1_pkt;
  logic [CW-1:0] stats_out_pkt, stats_drop_beat;

  nfp_merge_avlstrm #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_sop(in0_sop),
    .in0_eop(in0_eop), .in0_empty(in0_empty), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_sop(in1_sop),
    .in1_eop(in1_eop), .in1_empty(in1_empty), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty), .out_ready(out_ready),
    .stats_in0_pkt(stats_in0_pkt), .stats_in1_pkt(stats_in1_pkt),
    .stats_out_pkt(stats_out_pkt), .stats_drop_beat(stats_drop_beat)
  );

  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  beat_t exp_q[$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic beat_t mk(input logic [DW-1:0] d, input logic s,
                               input logic e, input logic [EW-1:0] m);
    beat_t b;
    b.d = d; b.sop = s; b.eop = e; b.e = m;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // call at a negedge; returns at the negedge after acceptance
  task automatic send0(input beat_t b);
    int  n;
    bit  took;
    n = 0; took = 0;
    in0_data = b.d; in0_sop = b.sop; in0_eop = b.eop; in0_empty = b.e;
    in0_valid = 1'b1;
    while (!took && n < 50) begin
      #1 took = in0_ready;
      @(posedge Clk);
      @(negedge Clk);
      n++;
    end
    in0_valid = 1'b0;
    if (!took) begin
      tests++; fails++;
      $display("FAIL send0_timeout: got no ready expected ready");
    end
  endtask

  task automatic send1(input beat_t b);
    int  n;
    bit  took;
    n = 0; took = 0;
    in1_data = b.d; in1_sop = b.sop; in1_eop = b.eop; in1_empty = b.e;
    in1_valid = 1'b1;
    while (!took && n < 50) begin
      #1 took = in1_ready;
      @(posedge Clk);
      @(negedge Clk);
      n++;
    end
    in1_valid = 1'b0;
    if (!took) begin
      tests++; fails++;
      $display("FAIL send1_timeout: got no ready expected ready");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    repeat (2) @(negedge Clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic chk_stats(input string nm, input int i0, input int i1,
                           input int o, input int dr);
    chk({nm, "_in0"}, 32'(stats_in0_pkt), i0);
    chk({nm, "_in1"}, 32'(stats_in1_pkt), i1);
    chk({nm, "_out"}, 32'(stats_out_pkt), o);
    chk({nm, "_drop"}, 32'(stats_drop_beat), dr);
  endtask

  // monitor: pops on every output transfer, checks hold under stall
  initial begin
    beat_t got, want, held;
    bit    hold;
    hold = 0;
    held = '0;
    forever begin
      @(negedge Clk);
      #2;
      got = {out_data, out_sop, out_eop, out_empty};
      if (Rst) begin
        hold = 0;
        continue;
      end
      if (hold) begin
        tests++;
        if (!out_valid || got !== held) begin
          fails++;
          $display("FAIL out_hold: got v=%0b %0h expected v=1 %0h",
                   out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        hold = 0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected: got %0h expected none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL out_beat: got %0h expected %0h", got, want);
          end
        end
      end else if (out_valid) begin
        hold = 1;
        held = got;
      end else begin
        hold = 0;
      end
    end
  end

  initial begin
    beat_t a[3], b[3];
    int    t0;
    Rst = 1'b1; out_ready = 1'b1;
    in0_valid = 0; in0_sop = 0; in0_eop = 0; in0_data = '0; in0_empty = '0;
    in1_valid = 0; in1_sop = 0; in1_eop = 0; in1_data = '0; in1_empty = '0;

    // reset: readies low even with traffic offered
    repeat (3) @(negedge Clk);
    in0_valid = 1; in0_sop = 1; in1_valid = 1; in1_sop = 1;
    #1;
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    @(negedge Clk);
    in0_valid = 0; in0_sop = 0; in1_valid = 0; in1_sop = 0;
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk_stats("rst", 0, 0, 0, 0);

    // both 3-beat packets at once: in0 first on tie
    for (int i = 0; i < 3; i++) begin
      a[i] = mk(32'hA000_0000 + i, i == 0, i == 2, (i == 2) ? 2'd1 : 2'd0);
      b[i] = mk(32'hB000_0000 + i, i == 0, i == 2, (i == 2) ? 2'd3 : 2'd0);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(a[i]);
    for (int i = 0; i < 3; i++) exp_q.push_back(b[i]);
    fork
      for (int i = 0; i < 3; i++) send0(a[i]);
      for (int i = 0; i < 3; i++) send1(b[i]);
    join
    drain();
    chk_stats("two_pkt", 1, 1, 2, 0);

    // single-beat packets alternate at full rate
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(32'hC000_0000 + i, 1, 1, 2'(i)));
      exp_q.push_back(mk(32'hD000_0000 + i, 1, 1, 2'(3 - i)));
    end
    t0 = cyc;
    fork
      for (int i = 0; i < 4; i++) send0(mk(32'hC000_0000 + i, 1, 1, 2'(i)));
      for (int i = 0; i < 4; i++)
        send1(mk(32'hD000_0000 + i, 1, 1, 2'(3 - i)));
    join
    chk("alt_cycles", cyc - t0, 8);
    drain();
    chk_stats("alt", 5, 5, 10, 0);

    // 5-cycle output stall mid-packet
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(32'hE000_0000 + i, i == 0, i == 3, 2'd2));
    fork
      for (int i = 0; i < 4; i++)
        send0(mk(32'hE000_0000 + i, i == 0, i == 3, 2'd2));
      begin
        @(negedge Clk);
        out_ready = 1'b0;
        #1 chk("stall_in0_ready", in0_ready, 0);
        repeat (5) @(negedge Clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk_stats("stall", 6, 5, 11, 0);

    // orphan beat on in1 while idle is dropped
    send1(mk(32'hDEAD_BEEF, 0, 0, 2'd0));
    drain();
    chk_stats("drop", 6, 5, 11, 1);

    // reset in the middle of a 4-beat in0 packet
    exp_q.push_back(mk(32'hF000_0000, 1, 0, 2'd0));
    exp_q.push_back(mk(32'hF000_0001, 0, 0, 2'd0));
    send0(mk(32'hF000_0000, 1, 0, 2'd0));
    send0(mk(32'hF000_0001, 0, 0, 2'd0));
    @(negedge Clk);
    chk("pre_rst_q", exp_q.size(), 0);
    Rst = 1'b1;
    in0_data = 32'hF000_0002; in0_sop = 0; in0_eop = 0; in0_valid = 1;
    #1 chk("mid_rst_in0_ready", in0_ready, 0);
    @(negedge Clk);
    Rst = 1'b0;
    chk("post_rst_out_valid", out_valid, 0);
    chk_stats("post_rst", 0, 0, 0, 0);
    exp_q.push_back(mk(32'h1111_0000, 1, 1, 2'd1));
    fork
      send0(mk(32'hF000_0002, 0, 0, 2'd0));
      send1(mk(32'h1111_0000, 1, 1, 2'd1));
    join
    drain();
    chk_stats("after_rst", 0, 1, 1, 1);

    // counter wrap: out_pkt 1 -> 15 -> 0
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(mk(32'h2000_0000 + i, 1, 1, 2'(i)));
      send0(mk(32'h2000_0000 + i, 1, 1, 2'(i)));
    end
    drain();
    chk("wrap_max_out", 32'(stats_out_pkt), 15);
    exp_q.push_back(mk(32'h2000_00FF, 1, 1, 2'd3));
    send0(mk(32'h2000_00FF, 1, 1, 2'd3));
    drain();
    chk_stats("wrap", 15, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nfp_merge_avlstrm.md
NFP_MERGE_AVLSTRM -- requirements
Module: nfp_merge_avlstrm

Interface
REQ-001 SHALL have parameter DATA_W, default 512, stream data width in bits.
REQ-002 SHALL have parameter EMPTY_W, default 6, empty-byte field width.
REQ-003 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-004 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in0_data/in0_valid/in0_sop/in0_eop/in0_empty  input  DATA_W/1/1/1/EMPTY_W  non-checked packet stream.
REQ-007 SHALL have port in0_ready  output  1  backpressure to in0.
REQ-008 SHALL have ports in1_data/in1_valid/in1_sop/in1_eop/in1_empty  input  DATA_W/1/1/1/EMPTY_W  checked packet stream.
REQ-009 SHALL have port in1_ready  output  1  backpressure to in1.
REQ-010 SHALL have ports out_data/out_valid/out_sop/out_eop/out_empty  output  DATA_W/1/1/1/EMPTY_W  merged stream.
REQ-011 SHALL have port out_ready  input  1  downstream backpressure, ready latency 0.
REQ-012 SHALL have ports stats_in0_pkt/stats_in1_pkt/stats_out_pkt/stats_drop_beat  output  CNT_W each  packet and error counters.

Function
REQ-013 SHALL transfer a beat on any port when valid and ready are both 1 in the same cycle.
REQ-014 SHALL implement FSM states IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-015 SHALL, in IDLE, grant the input presenting valid&sop; if both, grant the one not served last (rr_last); rr_last resets to 1 so in0 wins first tie.
REQ-016 SHALL accept the granted sop beat in the same IDLE cycle; if that beat lacks eop, go to LOCK0/LOCK1; if it has eop, stay IDLE and update rr_last.
REQ-017 SHALL, in LOCKn, accept beats only from input n; move to IDLE and set rr_last=n on accepted eop beat.
REQ-018 SHALL hold in(1-n)_ready=0 in LOCKn; never interleave beats of two packets on the output.
REQ-019 SHALL use one output register stage: accepted beat appears on out_* exactly 1 cycle after acceptance.
REQ-020 SHALL drive granted inN_ready = ~out_valid | out_ready (full throughput, one beat/cycle under continuous out_ready).
REQ-021 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, in IDLE, accept and discard (ready=1, no output) a valid beat lacking sop, increment stats_drop_beat; discard does not depend on out_ready; such beats never change state.
REQ-023 SHALL, in LOCKn, treat a mid-packet sop beat as data (forward unchanged, no recovery).
REQ-024 SHALL increment stats_inN_pkt on each accepted in_N eop beat, and stats_out_pkt on each out_valid&out_ready&out_eop.
REQ-025 SHALL wrap all counters modulo 2^CNT_W without saturation.
REQ-026 SHALL pass out_empty unchanged from the input beat; out_empty meaningful only with out_eop.

Reset
REQ-027 SHALL, while Rst=1 at a clock edge, set FSM=IDLE, rr_last=1, out_valid=0, out_sop=0, out_eop=0, all counters=0.
REQ-028 SHALL drive in0_ready=0 and in1_ready=0 during the cycle Rst=1; out_data/out_empty unspecified.
REQ-029 SHALL, on reset mid-packet, abandon the partial packet; first beat after reset is handled as in IDLE.

Verification
REQ-030 Both inputs present 3-beat packets at cycle 0, out_ready=1 -> in0 packet on out cycles 1-3, in1 packet cycles 4-6, stats_out_pkt=2.
REQ-031 Single-beat sop&eop packets continuously on both inputs -> output alternates in0,in1,in0... one beat per cycle.
REQ-032 out_ready=0 for 5 cycles mid-packet -> out_* held constant, in ready=0 after register fills, no beat lost or duplicated.
REQ-033 in1 sends beat without sop while IDLE -> beat consumed, no out_valid, stats_drop_beat=1.
REQ-034 Rst asserted during beat 2 of a 4-beat in0 packet -> counters 0, out_valid=0 next cycle, FSM IDLE, next in1 sop granted.
REQ-035 Preload stats_out_pkt to 2^CNT_W-1 (force) then one packet -> counter reads 0.
